// File: rtl/debounce_pkg.sv
// Shared types and helpers for the button debouncer: per-channel state
// encoding and the width of the stability counter.
package debounce_pkg;

    typedef enum logic [1:0] {
        REL_STABLE = 2'b00,
        PRS_WAIT   = 2'b01,
        PRS_STABLE = 2'b10,
        REL_WAIT   = 2'b11
    } debounce_state_e;

    // The counter only has to reach stableCycles-2, so clog2 always fits;
    // a floor of one bit keeps the smallest legal setting well formed.
    function automatic int counterWidth(input int stableCycles);
        int width;
        width = $clog2(stableCycles);
        if (width < 1) begin
            width = 1;
        end
        return width;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounced button: four-state FSM with a stability counter, a
// registered level and one-cycle press/release pulses.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int c_STABLE_CYCLES = 500000
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_sync,
    output logic o_level,
    output logic o_press,
    output logic o_release
);

    localparam int c_CNT_W = counterWidth(c_STABLE_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(c_STABLE_CYCLES - 2);

    debounce_state_e   state_q;
    debounce_state_e   state_d;
    logic [c_CNT_W-1:0] count_q;
    logic [c_CNT_W-1:0] count_d;
    logic              level_q;
    logic              level_d;
    logic              press_q;
    logic              press_d;
    logic              release_q;
    logic              release_d;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q   <= REL_STABLE;
            count_q   <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    // The wait states count the cycles already seen at the new value; the
    // counter restarts on any bounce and is parked at 0 in stable states.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        case (state_q)
            REL_STABLE: begin
                count_d = '0;
                if (i_sync) begin
                    state_d = PRS_WAIT;
                end
            end
            PRS_WAIT: begin
                if (!i_sync) begin
                    state_d = REL_STABLE;
                    count_d = '0;
                end else if (count_q == c_CNT_LAST) begin
                    state_d = PRS_STABLE;
                    count_d = '0;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
            PRS_STABLE: begin
                count_d = '0;
                if (!i_sync) begin
                    state_d = REL_WAIT;
                end
            end
            REL_WAIT: begin
                if (i_sync) begin
                    state_d = PRS_STABLE;
                    count_d = '0;
                end else if (count_q == c_CNT_LAST) begin
                    state_d = REL_STABLE;
                    count_d = '0;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
            default: begin
                state_d = REL_STABLE;
                count_d = '0;
            end
        endcase

        // Level follows the next state so it moves on the accepting edge.
        level_d   = (state_d == PRS_STABLE) || (state_d == REL_WAIT);
        press_d   = level_d && !level_q;
        release_d = !level_d && level_q;
    end

    assign o_level   = level_q;
    assign o_press   = press_q;
    assign o_release = release_q;

endmodule

// File: rtl/synchronizer.sv
// Two-flop synchronizer bank bringing c_N asynchronous levels into the
// i_clk domain; both stages clear to 0 on reset.
module synchronizer #(
    parameter int c_N = 1
) (
    input  logic           i_clk,
    input  logic           i_reset,
    input  logic [c_N-1:0] i_d,
    output logic [c_N-1:0] o_q
);

    logic [c_N-1:0] stage1_q;
    logic [c_N-1:0] stage2_q;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            stage1_q <= '0;
            stage2_q <= '0;
        end else begin
            stage1_q <= i_d;
            stage2_q <= stage1_q;
        end
    end

    assign o_q = stage2_q;

endmodule

// File: rtl/button_debouncer.sv
// Multi-channel button debouncer: polarity normalisation, shared
// synchronizer bank and one independent debounce channel per button.
module button_debouncer
    import debounce_pkg::*;
#(
    parameter int c_N             = 4,
    parameter int c_STABLE_CYCLES = 500000,
    parameter int c_ACTIVE_LOW    = 1
) (
    input  logic           i_clk,
    input  logic           i_reset,
    input  logic [c_N-1:0] i_btn,
    output logic [c_N-1:0] o_level,
    output logic [c_N-1:0] o_press,
    output logic [c_N-1:0] o_release
);

    logic [c_N-1:0] pressedRaw;
    logic [c_N-1:0] pressedSync;

    // Convert to 1 = pressed before synchronizing so reset (0) means released.
    assign pressedRaw = (c_ACTIVE_LOW != 0) ? ~i_btn : i_btn;

    synchronizer #(
        .c_N(c_N)
    ) u_sync (
        .i_clk  (i_clk),
        .i_reset(i_reset),
        .i_d    (pressedRaw),
        .o_q    (pressedSync)
    );

    for (genvar g = 0; g < c_N; g++) begin : g_channel
        debounce_channel #(
            .c_STABLE_CYCLES(c_STABLE_CYCLES)
        ) u_channel (
            .i_clk    (i_clk),
            .i_reset  (i_reset),
            .i_sync   (pressedSync[g]),
            .o_level  (o_level[g]),
            .o_press  (o_press[g]),
            .o_release(o_release[g])
        );
    end

endmodule

// File: tb/tb_button_debouncer.sv
// Self-checking bench for button_debouncer (2 channels, 4 stable cycles,
// active-low buttons) against a run-length reference model.
module tb_button_debouncer;

    localparam int c_N      = 2;
    localparam int c_STABLE = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] btn;
    logic [1:0] level;
    logic [1:0] press;
    logic [1:0] releaseO;

    int errors = 0;
    int checks = 0;
    int cycleNo = 0;

    // Reference: pressed levels delayed two edges, then a level flips once
    // c_STABLE consecutive samples have disagreed with it.
    logic [1:0] mDelay [2];
    int         mRun [2];
    logic [1:0] mLevel;
    logic [1:0] mPress;
    logic [1:0] mRelease;

    int pressCount [2];
    int releaseCount [2];
    int bothPress;
    int bothRelease;
    int firstPress0;
    int startCycle;

    button_debouncer #(
        .c_N            (c_N),
        .c_STABLE_CYCLES(c_STABLE),
        .c_ACTIVE_LOW   (1)
    ) dut (
        .i_clk    (clk),
        .i_reset  (rst),
        .i_btn    (btn),
        .o_level  (level),
        .o_press  (press),
        .o_release(releaseO)
    );

    always #5 clk = ~clk;

    task automatic modelReset();
        mDelay[0] = '0;
        mDelay[1] = '0;
        mRun[0]   = 0;
        mRun[1]   = 0;
        mLevel    = '0;
        mPress    = '0;
        mRelease  = '0;
    endtask

    task automatic modelEdge(input logic [1:0] rawPressed);
        logic [1:0] seen;
        seen      = mDelay[1];
        mDelay[1] = mDelay[0];
        mDelay[0] = rawPressed;
        mPress    = '0;
        mRelease  = '0;
        for (int ch = 0; ch < c_N; ch++) begin
            if (seen[ch] != mLevel[ch]) mRun[ch] = mRun[ch] + 1;
            else mRun[ch] = 0;
            if (mRun[ch] == c_STABLE) begin
                mLevel[ch] = ~mLevel[ch];
                if (mLevel[ch]) mPress[ch] = 1'b1;
                else mRelease[ch] = 1'b1;
                mRun[ch] = 0;
            end
        end
    endtask

    task automatic checkOutput(input string tag);
        checks++;
        assert ({level, press, releaseO} === {mLevel, mPress, mRelease})
        else begin
            errors++;
            $error("[TB] FAIL %s cycle %0d: level/press/release observed %b/%b/%b expected %b/%b/%b",
                   tag, cycleNo, level, press, releaseO, mLevel, mPress, mRelease);
        end
    endtask

    task automatic checkValue(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic tick();
        logic [1:0] raw;
        raw = ~btn;
        @(posedge clk);
        cycleNo++;
        if (!rst) modelEdge(raw);
        #1;
        checkOutput("cycle");
        for (int ch = 0; ch < c_N; ch++) begin
            if (press[ch]) pressCount[ch]++;
            if (releaseO[ch]) releaseCount[ch]++;
        end
        if (press == 2'b11) bothPress++;
        if (releaseO == 2'b11) bothRelease++;
        if (press[0] && firstPress0 < 0) firstPress0 = cycleNo;
    endtask

    task automatic applyStimulus(input logic [1:0] value, input int cycles);
        btn = value;
        for (int i = 0; i < cycles; i++) tick();
    endtask

    task automatic applyReset(input int holdCycles);
        rst = 1'b1;
        #1;
        modelReset();
        checkOutput("resetAsync");
        for (int i = 0; i < holdCycles; i++) tick();
        rst = 1'b0;
    endtask

    task automatic clearStats();
        pressCount[0]   = 0;
        pressCount[1]   = 0;
        releaseCount[0] = 0;
        releaseCount[1] = 0;
        bothPress       = 0;
        bothRelease     = 0;
        firstPress0     = -1;
    endtask

    initial begin
        int         rate;
        logic [1:0] nextBtn;

        rst = 1'b1;
        btn = 2'b11;
        modelReset();
        clearStats();
        #2;
        checkOutput("resetInitial");
        for (int i = 0; i < 3; i++) tick();
        rst = 1'b0;

        // Released buttons after reset: nothing happens.
        clearStats();
        applyStimulus(2'b11, 20);
        checkValue("idlePulses", pressCount[0] + pressCount[1] + releaseCount[0] + releaseCount[1], 0);

        // Clean press on channel 0: six edges from raw change to level.
        clearStats();
        startCycle = cycleNo;
        applyStimulus(2'b10, 10);
        checkValue("pressLatency", firstPress0 - startCycle, 6);
        checkValue("pressOnce", pressCount[0], 1);
        checkValue("ch1Untouched", int'(level[1]), 0);

        // Bouncy press: only the final settled edge counts.
        applyStimulus(2'b11, 12);
        clearStats();
        applyStimulus(2'b10, 2);
        applyStimulus(2'b11, 2);
        applyStimulus(2'b10, 2);
        applyStimulus(2'b11, 2);
        startCycle = cycleNo;
        applyStimulus(2'b10, 12);
        checkValue("bouncePressCount", pressCount[0], 1);
        checkValue("bounceLatency", firstPress0 - startCycle, 6);

        // Both channels together.
        applyStimulus(2'b11, 12);
        clearStats();
        applyStimulus(2'b00, 10);
        checkValue("bothPress", bothPress, 1);
        applyStimulus(2'b11, 12);
        checkValue("bothRelease", bothRelease, 1);

        // Reset in the middle of a press debounce; held button re-accepted
        // with full latency counted from reset release.
        clearStats();
        applyStimulus(2'b10, 3);
        applyReset(2);
        startCycle = cycleNo;
        applyStimulus(2'b10, 10);
        checkValue("pressAfterReset", firstPress0 - startCycle, 6);

        // Long hold: no wrap, no extra pulses.
        clearStats();
        applyStimulus(2'b10, 1000);
        checkValue("longHoldPulses", pressCount[0] + releaseCount[0], 0);
        checkValue("longHoldLevel", int'(level[0]), 1);

        // Random bouncing with varying activity and occasional resets.
        applyStimulus(2'b11, 12);
        for (int seg = 0; seg < 30; seg++) begin
            rate = int'($urandom_range(2, 12));
            for (int t = 0; t < 80; t++) begin
                nextBtn = btn;
                for (int ch = 0; ch < c_N; ch++) begin
                    if ($urandom_range(0, rate - 1) == 0) nextBtn[ch] = ~nextBtn[ch];
                end
                applyStimulus(nextBtn, 1);
            end
            if ($urandom_range(0, 4) == 0) applyReset(int'($urandom_range(1, 3)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
